// File: rtl/tone_period_meter_pkg.sv
// Shared state encoding and widths for the tone period meter and its
// companion clock scaler.
package tone_period_meter_pkg;

    localparam int SCALE_W = 8;

    typedef enum logic [1:0] {
        TPM_STATE_IDLE    = 2'd0,
        TPM_STATE_ARM     = 2'd1,
        TPM_STATE_MEASURE = 2'd2
    } tpm_state_e;

endpackage

// File: rtl/tone_period_meter_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus one history flop
// that turns the synced level into single-cycle rise/fall pulses.
module tone_period_meter_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_p0;
    logic              hist_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], async_in};
            hist_p1 <= sync_p0[STAGES-1];
        end
    end

    // Both edges see the same latency, so measured durations are exact.
    assign level = sync_p0[STAGES-1];
    assign rise  = level & ~hist_p1;
    assign fall  = ~level & hist_p1;

endmodule

// File: rtl/tone_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk cycles
// and recovers the clock-scaler divider setting that would produce it.
module tone_period_meter
    import tone_period_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sig_in,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   high_time,
    output logic [SCALE_W-1:0] scale_est,
    output logic               scale_sat,
    output logic               meas_valid,
    output logic               stable,
    output logic               timeout
);

    // Counter stops one short of all-ones: reaching all-ones is the timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    tpm_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] high_cap;
    logic             fall_seen;
    logic             have_prev;
    logic             level, rise, fall;
    logic             do_timeout;

    function automatic logic [SCALE_W:0] scale_of(input logic [CNT_W-1:0] p);
        logic [31:0] pw;
        logic [31:0] e;
        pw = 32'(p);
        e  = (pw >> 1) - 32'd1;
        if (pw < 32'd2)
            return {1'b1, {SCALE_W{1'b0}}};
        else if (e > 32'd255)
            return {1'b1, {SCALE_W{1'b1}}};
        else
            return {1'b0, e[SCALE_W-1:0]};
    endfunction

    tone_period_meter_edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(sig_in),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    assign cnt_inc    = cnt + 1'b1;
    assign do_timeout = (state == TPM_STATE_MEASURE) && !rise && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= TPM_STATE_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = TPM_STATE_IDLE;
        end else begin
            case (state)
                TPM_STATE_IDLE:    state_next = TPM_STATE_ARM;
                TPM_STATE_ARM:     if (rise) state_next = TPM_STATE_MEASURE;
                TPM_STATE_MEASURE: if (do_timeout) state_next = TPM_STATE_ARM;
                default:           state_next = TPM_STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            high_cap   <= '0;
            fall_seen  <= 1'b0;
            have_prev  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            scale_est  <= '0;
            scale_sat  <= 1'b0;
            meas_valid <= 1'b0;
            stable     <= 1'b0;
            timeout    <= 1'b0;
        end else if (!en || state == TPM_STATE_IDLE) begin
            cnt        <= '0;
            high_cap   <= '0;
            fall_seen  <= 1'b0;
            have_prev  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            scale_est  <= '0;
            scale_sat  <= 1'b0;
            meas_valid <= 1'b0;
            stable     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state == TPM_STATE_ARM) begin
                if (rise) begin
                    cnt       <= '0;
                    fall_seen <= 1'b0;
                end
            end else if (rise) begin
                period                 <= cnt_inc;
                high_time              <= fall_seen ? high_cap : cnt_inc;
                {scale_sat, scale_est} <= scale_of(cnt_inc);
                meas_valid             <= 1'b1;
                stable                 <= have_prev && (cnt_inc == period);
                have_prev              <= 1'b1;
                timeout                <= 1'b0;
                cnt                    <= '0;
                fall_seen              <= 1'b0;
            end else if (do_timeout) begin
                // Partial measurement is dropped; the next report needs two rises.
                timeout   <= 1'b1;
                stable    <= 1'b0;
                have_prev <= 1'b0;
                cnt       <= '0;
            end else begin
                cnt <= cnt_inc;
                if (fall)
                    high_cap <= cnt_inc;
                // Synced level low after a rise means the high phase has ended.
                if (!level)
                    fall_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter: directed tone patterns plus
// randomized segment sequences scored against a period/high-time model.
module tb_tone_period_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, en8 = 1'b0;
    logic        sig_in = 1'b0, sig8 = 1'b0;
    logic [15:0] period, high_time;
    logic [7:0]  scale_est;
    logic        scale_sat, meas_valid, stable, timeout;
    logic [7:0]  period8, high8, scale8;
    logic        sat8, mv8, stable8, timeout8;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] h;
        logic [7:0]  s;
        logic        sat;
        logic        st;
        logic        to;
    } rep_t;

    rep_t rep_q[$];
    int   mv8_cnt = 0;
    int   n_checks = 0, n_pass = 0;
    int   seg_h[$], seg_l[$];

    always #5 clk = ~clk;

    tone_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period), .high_time(high_time), .scale_est(scale_est),
        .scale_sat(scale_sat), .meas_valid(meas_valid), .stable(stable),
        .timeout(timeout)
    );

    tone_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .sig_in(sig8),
        .period(period8), .high_time(high8), .scale_est(scale8),
        .scale_sat(sat8), .meas_valid(mv8), .stable(stable8),
        .timeout(timeout8)
    );

    always @(negedge clk) begin
        if (meas_valid)
            rep_q.push_back('{period, high_time, scale_est, scale_sat, stable, timeout});
        if (mv8)
            mv8_cnt++;
    end

    function automatic logic [8:0] exp_scale(input int p);
        int e;
        e = p / 2 - 1;
        if (p < 2)   return {1'b1, 8'd0};
        if (e > 255) return {1'b1, 8'd255};
        return {1'b0, 8'(e)};
    endfunction

    function automatic rep_t exp_rep(input int i);
        rep_t e;
        int   p;
        p       = seg_h[i] + seg_l[i];
        e.p     = 16'(p);
        e.h     = 16'(seg_h[i]);
        {e.sat, e.s} = exp_scale(p);
        e.st    = (i > 0) && (p == seg_h[i-1] + seg_l[i-1]);
        e.to    = 1'b0;
        return e;
    endfunction

    // Holds one input level for n full clock cycles, changing it just after posedge.
    task automatic hold(input bit which, input logic lvl, input int n);
        if (which) sig8 = lvl; else sig_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_segs();
        foreach (seg_h[i]) begin
            hold(0, 1'b1, seg_h[i]);
            hold(0, 1'b0, seg_l[i]);
        end
        hold(0, 1'b1, 3);
        hold(0, 1'b0, 10);
    endtask

    task automatic restart();
        en = 1'b0;
        hold(0, 1'b0, 3);
        en = 1'b1;
        hold(0, 1'b0, 4);
        rep_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({period, high_time, scale_est, scale_sat, meas_valid, stable, timeout,
             period8, high8, scale8, sat8, mv8, stable8, timeout8} !== '0)
            $display("FAIL reset_hold: got %h %h %h %b%b%b%b, want all 0",
                     period, high_time, scale_est, scale_sat, meas_valid, stable, timeout);
        else n_pass++;
        @(posedge clk);
        #3 rst = 1'b0;
        hold(0, 1'b0, 3);
        n_checks++;
        if ({period, high_time, scale_est, scale_sat, meas_valid, stable, timeout} !== '0)
            $display("FAIL reset_release: got %h %h %h, want all 0", period, high_time, scale_est);
        else n_pass++;
    endtask

    task automatic test_loopback_scale3();
        restart();
        seg_h = {4, 4, 4, 4, 4};
        seg_l = {4, 4, 4, 4, 4};
        drive_segs();
        n_checks++;
        if (rep_q.size() !== seg_h.size())
            $display("FAIL loop_count: got %0d reports, want %0d", rep_q.size(), seg_h.size());
        else n_pass++;
        foreach (seg_h[i]) begin
            n_checks++;
            if (i >= rep_q.size() || rep_q[i] !== exp_rep(i))
                $display("FAIL loop_rep%0d: got %h, want %h", i,
                         (i < rep_q.size()) ? rep_q[i] : '1, exp_rep(i));
            else n_pass++;
        end
    endtask

    task automatic test_duty_3_7();
        restart();
        seg_h = {3, 3, 3, 3};
        seg_l = {7, 7, 7, 7};
        drive_segs();
        foreach (seg_h[i]) begin
            n_checks++;
            if (i >= rep_q.size() || rep_q[i] !== exp_rep(i))
                $display("FAIL duty_rep%0d: got %h, want %h", i,
                         (i < rep_q.size()) ? rep_q[i] : '1, exp_rep(i));
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        restart();
        seg_h = {300, 300};
        seg_l = {300, 300};
        drive_segs();
        foreach (seg_h[i]) begin
            n_checks++;
            if (i >= rep_q.size() || rep_q[i] !== exp_rep(i))
                $display("FAIL sat_rep%0d: got %h, want %h", i,
                         (i < rep_q.size()) ? rep_q[i] : '1, exp_rep(i));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        restart();
        seg_h.delete();
        seg_l.delete();
        for (int i = 0; i < 12; i++) begin
            if (i > 0 && $urandom_range(0, 2) == 0) begin
                seg_h.push_back(seg_h[i-1]);
                seg_l.push_back(seg_l[i-1]);
            end else begin
                seg_h.push_back(int'($urandom_range(1, 300)));
                seg_l.push_back(int'($urandom_range(1, 300)));
            end
        end
        drive_segs();
        n_checks++;
        if (rep_q.size() !== seg_h.size())
            $display("FAIL rand_count: got %0d reports, want %0d", rep_q.size(), seg_h.size());
        else n_pass++;
        foreach (seg_h[i]) begin
            n_checks++;
            if (i >= rep_q.size() || rep_q[i] !== exp_rep(i))
                $display("FAIL rand_rep%0d: got %h, want %h", i,
                         (i < rep_q.size()) ? rep_q[i] : '1, exp_rep(i));
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        en8 = 1'b1;
        hold(1, 1'b0, 6);
        mv8_cnt = 0;
        hold(1, 1'b1, 2);
        hold(1, 1'b0, 255);
        // Rise is captured 3 edges after the drive; timeout lands 255 edges after that.
        n_checks++;
        if (timeout8 !== 1'b0)
            $display("FAIL timeout_early: got %b, want 0", timeout8);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (timeout8 !== 1'b1)
            $display("FAIL timeout_set: got %b, want 1", timeout8);
        else n_pass++;
        n_checks++;
        if (mv8_cnt !== 0)
            $display("FAIL timeout_no_valid: got %0d pulses, want 0", mv8_cnt);
        else n_pass++;
        hold(1, 1'b1, 5);
        hold(1, 1'b0, 5);
        hold(1, 1'b1, 5);
        hold(1, 1'b0, 8);
        n_checks++;
        if (mv8_cnt !== 1 || {period8, high8, scale8, sat8, timeout8} !== {8'd10, 8'd5, 8'd4, 1'b0, 1'b0})
            $display("FAIL timeout_recover: got n=%0d p=%0d h=%0d s=%0d sat=%b to=%b, want n=1 p=10 h=5 s=4 sat=0 to=0",
                     mv8_cnt, period8, high8, scale8, sat8, timeout8);
        else n_pass++;
    endtask

    task automatic test_en_drop();
        restart();
        for (int i = 0; i < 3; i++) begin
            hold(0, 1'b1, 5);
            hold(0, 1'b0, 7);
        end
        hold(0, 1'b1, 5);
        hold(0, 1'b0, 3);
        n_checks++;
        if (period !== 16'd12)
            $display("FAIL en_pre: got period %0d, want 12", period);
        else n_pass++;
        en = 1'b0;
        hold(0, 1'b0, 1);
        n_checks++;
        if ({period, high_time, scale_est, scale_sat, meas_valid, stable, timeout} !== '0)
            $display("FAIL en_clear: got %h %h %h %b%b%b%b, want all 0",
                     period, high_time, scale_est, scale_sat, meas_valid, stable, timeout);
        else n_pass++;
        en = 1'b1;
        hold(0, 1'b0, 4);
        rep_q.delete();
        seg_h = {5, 5, 5};
        seg_l = {7, 7, 7};
        drive_segs();
        n_checks++;
        if (rep_q.size() !== 3)
            $display("FAIL en_count: got %0d reports, want 3", rep_q.size());
        else n_pass++;
        foreach (seg_h[i]) begin
            n_checks++;
            if (i >= rep_q.size() || rep_q[i] !== exp_rep(i))
                $display("FAIL en_rep%0d: got %h, want %h", i,
                         (i < rep_q.size()) ? rep_q[i] : '1, exp_rep(i));
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        restart();
        seg_h = {4, 4, 4};
        seg_l = {4, 4, 4};
        drive_segs();
        n_checks++;
        if (period !== 16'd8)
            $display("FAIL arst_pre: got period %0d, want 8", period);
        else n_pass++;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({period, high_time, scale_est, scale_sat, meas_valid, stable, timeout} !== '0)
            $display("FAIL arst_clear: got %h %h %h %b%b%b%b, want all 0",
                     period, high_time, scale_est, scale_sat, meas_valid, stable, timeout);
        else n_pass++;
        @(posedge clk);
        #3 rst = 1'b0;
        hold(0, 1'b0, 5);
        rep_q.delete();
        seg_h = {4, 4, 4, 4};
        seg_l = {4, 4, 4, 4};
        drive_segs();
        foreach (seg_h[i]) begin
            n_checks++;
            if (i >= rep_q.size() || rep_q[i] !== exp_rep(i))
                $display("FAIL arst_rep%0d: got %h, want %h", i,
                         (i < rep_q.size()) ? rep_q[i] : '1, exp_rep(i));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_loopback_scale3();
        test_duty_3_7();
        test_saturation();
        test_random();
        test_timeout();
        test_en_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Measures an incoming square wave on `sig_in`, such as a scaled tone clock or an external tone, in units of `clk` cycles.
- Reports full period, high time, and the equivalent clock-scaler divider setting.
- This is the inverse of the tone clock scaler: it recovers `scale_factor` from the tone it produced.
- Used for self-test loopback of the tone path and for tone capture.

Parameters:
- CNT_W, 16: width of the period and high-time counters (valid range 4..24).
- SYNC_STAGES, 2: synchronizer flop count for `sig_in` (at least 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  measurement enable; low forces IDLE.
- sig_in  input  1  tone input, asynchronous to `clk`.
- period  output  CNT_W  last complete rising-to-rising period, in cycles.
- high_time  output  CNT_W  rising-to-falling duration within the last period, in cycles.
- scale_est  output  8  divider estimate: (period>>1)-1, saturated.
- scale_sat  output  1  `scale_est` was clamped (high or low) for this measurement.
- meas_valid  output  1  single-cycle pulse when period, high_time and scale_est update.
- stable  output  1  last two consecutive periods were equal.
- timeout  output  1  sticky flag: no edge was seen within 2^CNT_W-1 cycles.

Behaviour:
- Reset: all outputs 0, counter 0, synchronizer 0, state IDLE.
- Synchronizer and edge detect:
  - `sig_in` passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Detection latency is constant for both edge types, so measured durations are unaffected.
- States: IDLE, ARM, MEASURE.
- IDLE:
  - Entered on `rst` or whenever `en`=0.
  - Counter cleared; `stable`, `timeout`, `meas_valid` forced to 0.
  - `period`, `high_time`, `scale_est` forced to 0.
  - `en`=1 moves to ARM on the next cycle.
- ARM:
  - Waits for a rise.
  - On rise: cnt<=0, go to MEASURE.
  - Nothing is reported for the first edge.
- MEASURE:
  - cnt increments every cycle.
  - On fall: high_cap<=cnt+1, held internally.
  - On rise:
    - period<=cnt+1, high_time<=high_cap, scale_est updated.
    - meas_valid=1 the following cycle; timeout<=0; cnt<=0; stay in MEASURE.
  - If rise and fall are detected in the same cycle, that is impossible with a single input; no special handling is required.
  - If no fall was seen since the previous rise, high_time<=period, i.e. the signal was seen high throughout.
- Period example: rises detected at cycles t and t+P give period=P. Minimum measurable period is 2.
- scale_est:
  - e = (period>>1)-1.
  - If period<2: e=0 and scale_sat=1.
  - If e>255: scale_est=255 and scale_sat=1.
  - Otherwise scale_sat=0.
  - An odd period truncates.
- stable:
  - Updated on each meas_valid: 1 if the new period equals the previous period, else 0.
  - The first measurement after ARM always gives stable=0.
- Timeout:
  - cnt reaching 2^CNT_W-1 in MEASURE with no rise: timeout<=1, stable<=0, go to ARM.
  - period, high_time and scale_est hold their last values; no meas_valid.
- `en` deasserted mid-measurement: IDLE on the next clock and all outputs cleared. The partial count is discarded.
- `rst` mid-operation: immediate asynchronous clear of everything, including the synchronizer.
- Counter never wraps; timeout occurs first.

Decomposition:
- Shared package constants:
  - TPM_STATE_IDLE, TPM_STATE_ARM, TPM_STATE_MEASURE (2-bit encoding).
  - SCALE_W=8, matching the clock scaler's divider width.
- Sub-module `edge_sync`:
  - Contents: SYNC_STAGES flops plus the history flop.
  - Outputs: rise and fall pulses plus the synced level.
  - Reuse: shareable with other async-input blocks.
- Top level: FSM, counter, capture registers, scale arithmetic.

Test Plan:
- Feed sig_in from the clock scaler model with scale_factor=3, en=1 (toggle every 4 cycles) -> second and later meas_valid give period=8, high_time=4, scale_est=3, scale_sat=0. stable=1 from the second report.
- Drive sig_in with 3 cycles high and 7 low, repeating -> period=10, high_time=3, scale_est=4; stable=1 after two reports.
- Set CNT_W=8, arm with one rise, then hold sig_in low -> timeout=1 exactly 255 cycles after the capture; state ARM; no meas_valid. The next two rises clear timeout and report a period.
- Drive a period of 600 cycles (300 high, 300 low) with CNT_W=16 -> period=600, high_time=300, scale_est=255, scale_sat=1.
- Drop en for 1 cycle mid-period, then re-enable -> all outputs 0 next cycle. The first report after re-enable needs two fresh rises.
- Assert rst asynchronously between clock edges during MEASURE -> all outputs 0 before the next clk edge. After release, behaviour matches a cold start.
